mem_lsu: RTL and testbench
==========================

Name: mem_lsu

Overview:
- MEM-stage load/store unit. Sits between the ex_mem pipeline register and the mem_wb register.
- Passes ALU results through unchanged.
- Runs loads and stores on a req/ack data bus and holds the pipeline with a stall request until each access completes.
- Produces the mem_wd/mem_wreg/mem_wdata triple that mem_wb registers.

Parameters:
- DW, 32, data/address width
- AW_REG, 5, register-address width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low (RstEnable = 1'b0)
- flush  in  1  discard the current MEM-stage instruction
- ex_wd  in  AW_REG  destination register
- ex_wreg  in  1  write enable
- ex_wdata  in  DW  ALU result
- ex_aluop  in  8  operation code
- ex_mem_addr  in  DW  effective address
- ex_reg2  in  DW  store data
- dbus_req  out  1  bus request
- dbus_we  out  1  1 = store
- dbus_addr  out  DW  word address, bits [1:0] forced to 00
- dbus_sel  out  4  byte-lane enables, big-endian
- dbus_wdata  out  DW  store data replicated onto the lanes
- dbus_rdata  in  DW  load data
- dbus_ack  in  1  access complete
- mem_wd  out  AW_REG  to mem_wb
- mem_wreg  out  1  to mem_wb
- mem_wdata  out  DW  to mem_wb
- stallreq  out  1  hold IF..EX/MEM
- exc_adel  out  1  load address error
- exc_ades  out  1  store address error

Behaviour:
- Reset:
  - Sync with rst=0: state=IDLE, rdata_q=0.
  - While rst=0, all outputs are 0 regardless of inputs.
- Op classes:
  - Loads: LB, LBU, LH, LHU, LW.
  - Stores: SB, SH, SW.
  - Any other ex_aluop is non-memory.
- Non-memory op in IDLE:
  - Combinational pass-through of ex_wd/ex_wreg/ex_wdata.
  - dbus_req=0, stallreq=0.
- FSM states: IDLE, BUSY, DONE, DRAIN.
- IDLE with a memory op:
  - dbus_req=1, stallreq=1.
  - ack=1 -> capture dbus_rdata into rdata_q, go to DONE.
  - ack=0 -> go to BUSY.
- BUSY:
  - dbus_req=1, stallreq=1. Address, sel and wdata are held stable (upstream is stalled).
  - ack=1 -> capture, go to DONE.
- DONE:
  - dbus_req=0, stallreq=0.
  - Loads: mem_wdata = rdata_q after extraction; mem_wreg = ex_wreg.
  - Stores: mem_wreg = 0.
  - Next state is always IDLE.
- Latency: 2 cycles with a zero-wait bus; 2+N cycles with N wait cycles.
- Lanes (big-endian):
  - Byte at addr[1:0]=00 is sel 1000, data [31:24]; 11 is sel 0001, data [7:0].
  - Half at addr[1]=0 is sel 1100; addr[1]=1 is sel 0011.
  - Word is sel 1111.
- Extension:
  - LB/LH sign-extend; LBU/LHU zero-extend. Result is always 32 bits.
  - Store data is replicated across lanes: byte x4, half x2.
- Flush:
  - In IDLE/DONE: outputs are NOP (wd=0, wreg=0, wdata=0) and no request starts.
  - In BUSY, or in IDLE with a request already issued: go to DRAIN.
  - DRAIN keeps dbus_req=1 until ack, then goes to IDLE. Read data is discarded, outputs stay NOP, stallreq=1.
- A bus request is never withdrawn before ack.
- Reset mid-access (BUSY or DRAIN): go to IDLE immediately. The bus slave must tolerate the dropped request.
- Simultaneous flush and ack in BUSY: ack wins the bus handshake, data is discarded, next state is IDLE (not DONE).
- exc_adel and exc_ades are 0 unless MEM_ALIGN_EXC_EN is defined.

Optional Feature:
- Macro: MEM_ALIGN_EXC_EN.
- Defined:
  - Misaligned cases: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
  - No bus request is made; stallreq=0.
  - For one cycle in IDLE: exc_adel (loads) or exc_ades (stores) =1, mem_wreg=0.
- Undefined:
  - The offending low address bits are ignored; the access uses the aligned-down lane (half uses addr[1], word uses sel 1111).
  - Exception outputs are tied to 0.

Decomposition:
- Shared package (defines file): RstEnable, ZeroWord, NOPRegAddr, WriteDisable, RegBus/RegAddrBus widths, and the aluop codes:
  - EXE_LB_OP=8'b11100000, EXE_LBU_OP=8'b11100100, EXE_LH_OP=8'b11100001, EXE_LHU_OP=8'b11100101
  - EXE_LW_OP=8'b11100011, EXE_SB_OP=8'b11101000, EXE_SH_OP=8'b11101001, EXE_SW_OP=8'b11101011
- One sub-module: lsu_lane, combinational. It covers lane select, store replication and load extract/extend. The FSM stays in mem_lsu.

Test Plan:
- ex_aluop=OR, ex_wd=3, ex_wreg=1, ex_wdata=0x1234 -> same cycle mem_wd=3, wreg=1, wdata=0x1234, stallreq=0, dbus_req=0.
- LB addr=0x101, zero-wait bus, rdata=0x00800000 -> cycle0 req=1, sel=0100, stallreq=1; cycle1 stallreq=0, mem_wdata=0xFFFFFF80.
- LHU addr=0x102, ack after 3 wait cycles, rdata=0x0000BEEF -> stallreq high 4 cycles, req held, then mem_wdata=0x0000BEEF.
- SB addr=0x3, reg2=0xAB -> dbus_we=1, sel=0001, wdata=0xABABABAB, addr=0x0; in DONE mem_wreg=0.
- LW in BUSY with flush=1, ack two cycles later -> req held until ack, outputs NOP throughout, then IDLE, stallreq=0.
- With MEM_ALIGN_EXC_EN: LW addr=0x2 -> dbus_req=0, exc_adel=1, mem_wreg=0. Without the macro: sel=1111, addr=0x0.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: shared constants, aluop codes and op-class helpers for mem_lsu (MEM_ALIGN_EXC_EN enables alignment exceptions)
package mem_lsu_pkg;
  localparam logic RstEnable = 1'b0;
  localparam int RegBus = 32;
  localparam int RegAddrBus = 5;
  localparam logic [RegBus-1:0] ZeroWord = '0;
  localparam logic [RegAddrBus-1:0] NOPRegAddr = '0;
  localparam logic WriteDisable = 1'b0;
  localparam logic [7:0] EXE_LB_OP = 8'b11100000;
  localparam logic [7:0] EXE_LBU_OP = 8'b11100100;
  localparam logic [7:0] EXE_LH_OP = 8'b11100001;
  localparam logic [7:0] EXE_LHU_OP = 8'b11100101;
  localparam logic [7:0] EXE_LW_OP = 8'b11100011;
  localparam logic [7:0] EXE_SB_OP = 8'b11101000;
  localparam logic [7:0] EXE_SH_OP = 8'b11101001;
  localparam logic [7:0] EXE_SW_OP = 8'b11101011;
  typedef enum logic [1:0] {IDLE, BUSY, DONE, DRAIN} state_t;
  function automatic logic is_load(input logic [7:0] op);
    return op inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP};
  endfunction
  function automatic logic is_store(input logic [7:0] op);
    return op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
  endfunction
  function automatic logic is_byte(input logic [7:0] op);
    return op inside {EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP};
  endfunction
  function automatic logic is_half(input logic [7:0] op);
    return op inside {EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP};
  endfunction
  function automatic logic is_word(input logic [7:0] op);
    return op inside {EXE_LW_OP, EXE_SW_OP};
  endfunction
endpackage

// File: rtl/mem_lsu_lane.sv
// lsu_lane: big-endian byte-lane select, store replication and load extract/extend
module lsu_lane
  import mem_lsu_pkg::*;
(
  input  logic [7:0]        aluop,
  input  logic [1:0]        addr_lo,
  input  logic [RegBus-1:0] reg2,
  input  logic [RegBus-1:0] rdata,
  output logic [3:0]        sel,
  output logic [RegBus-1:0] wdata,
  output logic [RegBus-1:0] ldata
);
  logic [4:0] bsh, hsh;
  logic [7:0] b;
  logic [15:0] h;
  assign bsh = {~addr_lo, 3'b000};
  assign hsh = {~addr_lo[1], 4'b0000};
  assign b = rdata[bsh +: 8];
  assign h = rdata[hsh +: 16];
  assign sel = is_byte(aluop) ? 4'b1000 >> addr_lo : is_half(aluop) ? (addr_lo[1] ? 4'b0011 : 4'b1100) : 4'b1111;
  assign wdata = is_byte(aluop) ? {4{reg2[7:0]}} : is_half(aluop) ? {2{reg2[15:0]}} : reg2;
  assign ldata = aluop == EXE_LB_OP  ? {{24{b[7]}}, b} :
                 aluop == EXE_LBU_OP ? {24'b0, b} :
                 aluop == EXE_LH_OP  ? {{16{h[15]}}, h} :
                 aluop == EXE_LHU_OP ? {16'b0, h} : rdata;
endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit with req/ack bus FSM; MEM_ALIGN_EXC_EN enables misalignment exceptions
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW_REG = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [AW_REG-1:0] ex_wd,
  input  logic              ex_wreg,
  input  logic [DW-1:0]     ex_wdata,
  input  logic [7:0]        ex_aluop,
  input  logic [DW-1:0]     ex_mem_addr,
  input  logic [DW-1:0]     ex_reg2,
  output logic              dbus_req,
  output logic              dbus_we,
  output logic [DW-1:0]     dbus_addr,
  output logic [3:0]        dbus_sel,
  output logic [DW-1:0]     dbus_wdata,
  input  logic [DW-1:0]     dbus_rdata,
  input  logic              dbus_ack,
  output logic [AW_REG-1:0] mem_wd,
  output logic              mem_wreg,
  output logic [DW-1:0]     mem_wdata,
  output logic              stallreq,
  output logic              exc_adel,
  output logic              exc_ades
);
  state_t state_q, state_d;
  logic [DW-1:0] rdata_q, rdata_d, addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0] sel_q, sel_d, lane_sel;
  logic we_q, we_d;
  logic [DW-1:0] lane_wdata, lane_ldata;
  logic ld, st, mem_op, misalign, idle, on, req, stall, adel, ades, nop;
  assign ld = is_load(ex_aluop);
  assign st = is_store(ex_aluop);
  assign mem_op = ld | st;
  assign idle = state_q == IDLE;
  assign on = rst != RstEnable;
`ifdef MEM_ALIGN_EXC_EN
  assign misalign = (is_half(ex_aluop) & ex_mem_addr[0]) | (is_word(ex_aluop) & |ex_mem_addr[1:0]);
`else
  assign misalign = 1'b0;
`endif
  lsu_lane u_lane (
    .aluop(ex_aluop),
    .addr_lo(ex_mem_addr[1:0]),
    .reg2(ex_reg2),
    .rdata(rdata_q),
    .sel(lane_sel),
    .wdata(lane_wdata),
    .ldata(lane_ldata)
  );
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    we_d = idle ? st : we_q;
    addr_d = idle ? {ex_mem_addr[DW-1:2], 2'b00} : addr_q;
    sel_d = idle ? lane_sel : sel_q;
    wdata_d = idle ? lane_wdata : wdata_q;
    req = 1'b0;
    stall = 1'b0;
    adel = 1'b0;
    ades = 1'b0;
    nop = 1'b1;
    case (state_q)
      IDLE: begin
        nop = flush | mem_op;
        if (!flush && mem_op && misalign) begin
          adel = ld;
          ades = st;
        end else if (!flush && mem_op) begin
          req = 1'b1;
          stall = 1'b1;
          state_d = dbus_ack ? DONE : BUSY;
          rdata_d = dbus_ack ? dbus_rdata : rdata_q;
        end
      end
      BUSY: begin
        req = 1'b1;
        stall = 1'b1;
        state_d = dbus_ack ? (flush ? IDLE : DONE) : (flush ? DRAIN : BUSY);
        rdata_d = (dbus_ack && !flush) ? dbus_rdata : rdata_q;
      end
      DONE: begin
        nop = flush;
        state_d = IDLE;
      end
      DRAIN: begin
        req = 1'b1;
        stall = 1'b1;
        state_d = dbus_ack ? IDLE : DRAIN;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q <= IDLE;
      rdata_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      sel_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      we_q <= we_d;
      addr_q <= addr_d;
      sel_q <= sel_d;
      wdata_q <= wdata_d;
    end
  end
  assign dbus_req = on & req;
  assign dbus_we = on & req & we_d;
  assign dbus_addr = (on & req) ? addr_d : ZeroWord;
  assign dbus_sel = (on & req) ? sel_d : 4'b0000;
  assign dbus_wdata = (on & req) ? wdata_d : ZeroWord;
  assign stallreq = on & stall;
  assign exc_adel = on & adel;
  assign exc_ades = on & ades;
  assign mem_wd = (on & !nop) ? ex_wd : NOPRegAddr;
  assign mem_wreg = (on & !nop) ? (state_q == DONE ? ld & ex_wreg : ex_wreg) : WriteDisable;
  assign mem_wdata = (on & !nop) ? ((state_q == DONE && ld) ? lane_ldata : ex_wdata) : ZeroWord;
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed vector table plus multi-cycle sequences for mem_lsu
module tb_mem_lsu;
  localparam logic [7:0] LB = 8'b11100000, LBU = 8'b11100100, LH = 8'b11100001, LHU = 8'b11100101;
  localparam logic [7:0] LW = 8'b11100011, SB = 8'b11101000, SH = 8'b11101001, SW = 8'b11101011;
  localparam logic [7:0] OR = 8'b00100101, NOP = 8'h00;
  typedef struct {
    logic [7:0] op; logic [4:0] wd; logic wreg; logic [31:0] alu, addr, reg2, rdata;
    logic mem, we; logic [3:0] sel; logic [31:0] baddr, bwdata, res;
  } vec_t;
  logic clk = 1'b0, rst, flush, ex_wreg, dbus_req, dbus_we, dbus_ack, mem_wreg, stallreq, exc_adel, exc_ades;
  logic [4:0] ex_wd, mem_wd;
  logic [7:0] ex_aluop;
  logic [31:0] ex_wdata, ex_mem_addr, ex_reg2, dbus_addr, dbus_wdata, dbus_rdata, mem_wdata;
  logic [3:0] dbus_sel;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  mem_lsu dut (
    .clk(clk), .rst(rst), .flush(flush), .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2), .dbus_req(dbus_req),
    .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_sel(dbus_sel), .dbus_wdata(dbus_wdata),
    .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack), .mem_wd(mem_wd), .mem_wreg(mem_wreg),
    .mem_wdata(mem_wdata), .stallreq(stallreq), .exc_adel(exc_adel), .exc_ades(exc_ades)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic op_in(input logic [7:0] op, input logic [4:0] wd, input logic wreg, input logic [31:0] alu, input logic [31:0] addr, input logic [31:0] reg2);
    ex_aluop = op; ex_wd = wd; ex_wreg = wreg; ex_wdata = alu; ex_mem_addr = addr; ex_reg2 = reg2;
  endtask
  task automatic bus_in(input logic fl, input logic ack, input logic [31:0] rd);
    flush = fl; dbus_ack = ack; dbus_rdata = rd;
  endtask
  initial begin
    vec_t vt[12];
    vt[0]  = '{OR, 5'd3, 1'b1, 32'h1234, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h1234};
    vt[1]  = '{LB, 5'd7, 1'b1, 32'h0, 32'h101, 32'h0, 32'h0080_0000, 1'b1, 1'b0, 4'b0100, 32'h100, 32'h0, 32'hFFFF_FF80};
    vt[2]  = '{LBU, 5'd8, 1'b1, 32'h0, 32'h100, 32'h0, 32'h80AB_CDEF, 1'b1, 1'b0, 4'b1000, 32'h100, 32'h0, 32'h0000_0080};
    vt[3]  = '{LB, 5'd9, 1'b1, 32'h0, 32'h103, 32'h0, 32'h1234_567F, 1'b1, 1'b0, 4'b0001, 32'h100, 32'h0, 32'h0000_007F};
    vt[4]  = '{LH, 5'd10, 1'b1, 32'h0, 32'h200, 32'h0, 32'h8001_0002, 1'b1, 1'b0, 4'b1100, 32'h200, 32'h0, 32'hFFFF_8001};
    vt[5]  = '{LHU, 5'd11, 1'b1, 32'h0, 32'h202, 32'h0, 32'h1234_BEEF, 1'b1, 1'b0, 4'b0011, 32'h200, 32'h0, 32'h0000_BEEF};
    vt[6]  = '{LH, 5'd12, 1'b1, 32'h0, 32'h206, 32'h0, 32'hFFFF_7FFF, 1'b1, 1'b0, 4'b0011, 32'h204, 32'h0, 32'h0000_7FFF};
    vt[7]  = '{LW, 5'd13, 1'b1, 32'h0, 32'h300, 32'h0, 32'hDEAD_BEEF, 1'b1, 1'b0, 4'b1111, 32'h300, 32'h0, 32'hDEAD_BEEF};
    vt[8]  = '{SB, 5'd14, 1'b1, 32'h0, 32'h3, 32'h1234_56AB, 32'h0, 1'b1, 1'b1, 4'b0001, 32'h0, 32'hABAB_ABAB, 32'h0};
    vt[9]  = '{SH, 5'd15, 1'b1, 32'h0, 32'h12, 32'hAAAA_5678, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h10, 32'h5678_5678, 32'h0};
    vt[10] = '{SW, 5'd16, 1'b1, 32'h0, 32'h24, 32'hCAFE_F00D, 32'h0, 1'b1, 1'b1, 4'b1111, 32'h24, 32'hCAFE_F00D, 32'h0};
    vt[11] = '{SB, 5'd17, 1'b1, 32'h0, 32'h1, 32'h0000_005A, 32'h0, 1'b1, 1'b1, 4'b0100, 32'h0, 32'h5A5A_5A5A, 32'h0};
    rst = 1'b0;
    op_in(LW, 5'd4, 1'b1, 32'h55, 32'h10, 32'h0);
    bus_in(1'b0, 1'b1, 32'hFFFF_FFFF);
    @(negedge clk); #1;
    chk("rst_req", dbus_req, 0); chk("rst_stall", stallreq, 0); chk("rst_wd", mem_wd, 0);
    chk("rst_wreg", mem_wreg, 0); chk("rst_wdata", mem_wdata, 0); chk("rst_sel", dbus_sel, 0);
    @(negedge clk); rst = 1'b1;
    op_in(NOP, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0); bus_in(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      op_in(vt[i].op, vt[i].wd, vt[i].wreg, vt[i].alu, vt[i].addr, vt[i].reg2);
      bus_in(1'b0, vt[i].mem, vt[i].rdata);
      #1;
      chk($sformatf("v%0d_req", i), dbus_req, vt[i].mem);
      chk($sformatf("v%0d_stall", i), stallreq, vt[i].mem);
      if (vt[i].mem) begin
        chk($sformatf("v%0d_we", i), dbus_we, vt[i].we);
        chk($sformatf("v%0d_sel", i), dbus_sel, vt[i].sel);
        chk($sformatf("v%0d_addr", i), dbus_addr, vt[i].baddr);
        chk($sformatf("v%0d_bwdata", i), dbus_wdata, vt[i].bwdata);
        @(negedge clk); dbus_ack = 1'b0; #1;
        chk($sformatf("v%0d_done_stall", i), stallreq, 0);
        chk($sformatf("v%0d_done_req", i), dbus_req, 0);
        chk($sformatf("v%0d_done_wreg", i), mem_wreg, !vt[i].we);
        if (!vt[i].we) begin
          chk($sformatf("v%0d_done_wdata", i), mem_wdata, vt[i].res);
          chk($sformatf("v%0d_done_wd", i), mem_wd, vt[i].wd);
        end
      end else begin
        chk($sformatf("v%0d_wd", i), mem_wd, vt[i].wd);
        chk($sformatf("v%0d_wreg", i), mem_wreg, vt[i].wreg);
        chk($sformatf("v%0d_wdata", i), mem_wdata, vt[i].res);
      end
    end
    @(negedge clk);
    op_in(LHU, 5'd9, 1'b1, 32'h0, 32'h102, 32'h0); bus_in(1'b0, 1'b0, 32'h0); #1;
    chk("wait_c0_stall", stallreq, 1); chk("wait_c0_req", dbus_req, 1);
    chk("wait_c0_sel", dbus_sel, 4'b0011); chk("wait_c0_addr", dbus_addr, 32'h100);
    for (int k = 1; k < 3; k++) begin
      @(negedge clk); #1;
      chk($sformatf("wait_c%0d_stall", k), stallreq, 1); chk($sformatf("wait_c%0d_req", k), dbus_req, 1);
      chk($sformatf("wait_c%0d_sel", k), dbus_sel, 4'b0011); chk($sformatf("wait_c%0d_addr", k), dbus_addr, 32'h100);
    end
    @(negedge clk); bus_in(1'b0, 1'b1, 32'h0000_BEEF); #1;
    chk("wait_c3_stall", stallreq, 1); chk("wait_c3_req", dbus_req, 1);
    @(negedge clk); bus_in(1'b0, 1'b0, 32'h0); #1;
    chk("wait_done_stall", stallreq, 0); chk("wait_done_wdata", mem_wdata, 32'h0000_BEEF);
    chk("wait_done_wreg", mem_wreg, 1); chk("wait_done_wd", mem_wd, 9);
    @(negedge clk);
    op_in(LW, 5'd4, 1'b1, 32'h0, 32'h40, 32'h0); bus_in(1'b0, 1'b0, 32'h0); #1;
    chk("drain_c0_req", dbus_req, 1);
    @(negedge clk); flush = 1'b1; #1;
    chk("drain_c1_req", dbus_req, 1); chk("drain_c1_stall", stallreq, 1);
    chk("drain_c1_wreg", mem_wreg, 0); chk("drain_c1_wd", mem_wd, 0); chk("drain_c1_wdata", mem_wdata, 0);
    @(negedge clk); #1;
    chk("drain_c2_req", dbus_req, 1); chk("drain_c2_stall", stallreq, 1); chk("drain_c2_wreg", mem_wreg, 0);
    @(negedge clk); dbus_ack = 1'b1; #1;
    chk("drain_c3_req", dbus_req, 1); chk("drain_c3_wreg", mem_wreg, 0);
    @(negedge clk); bus_in(1'b0, 1'b0, 32'h0); op_in(OR, 5'd5, 1'b1, 32'h77, 32'h0, 32'h0); #1;
    chk("drain_idle_stall", stallreq, 0); chk("drain_idle_req", dbus_req, 0);
    chk("drain_idle_wreg", mem_wreg, 1); chk("drain_idle_wdata", mem_wdata, 32'h77);
    @(negedge clk);
    op_in(LW, 5'd4, 1'b1, 32'h0, 32'h44, 32'h0); bus_in(1'b0, 1'b0, 32'h0);
    @(negedge clk); bus_in(1'b1, 1'b1, 32'h1234_5678); #1;
    chk("flack_req", dbus_req, 1);
    @(negedge clk); bus_in(1'b0, 1'b0, 32'h0); op_in(OR, 5'd6, 1'b1, 32'h99, 32'h0, 32'h0); #1;
    chk("flack_idle_stall", stallreq, 0); chk("flack_idle_wreg", mem_wreg, 1); chk("flack_idle_wdata", mem_wdata, 32'h99);
    @(negedge clk);
    op_in(LW, 5'd4, 1'b1, 32'h11, 32'h48, 32'h0); bus_in(1'b1, 1'b0, 32'h0); #1;
    chk("flidle_req", dbus_req, 0); chk("flidle_stall", stallreq, 0); chk("flidle_wreg", mem_wreg, 0); chk("flidle_wd", mem_wd, 0);
    @(negedge clk); flush = 1'b0; op_in(OR, 5'd2, 1'b1, 32'h33, 32'h0, 32'h0); #1;
    chk("flidle_next_req", dbus_req, 0); chk("flidle_next_wdata", mem_wdata, 32'h33);
    @(negedge clk);
    op_in(LW, 5'd4, 1'b1, 32'h0, 32'h4C, 32'h0); bus_in(1'b0, 1'b0, 32'h0);
    @(negedge clk); rst = 1'b0; #1;
    chk("rstmid_req", dbus_req, 0); chk("rstmid_stall", stallreq, 0);
    @(negedge clk); rst = 1'b1; op_in(OR, 5'd1, 1'b1, 32'h44, 32'h0, 32'h0); #1;
    chk("rstmid_idle_stall", stallreq, 0); chk("rstmid_idle_req", dbus_req, 0); chk("rstmid_idle_wdata", mem_wdata, 32'h44);
    @(negedge clk);
    op_in(LW, 5'd4, 1'b1, 32'h0, 32'h2, 32'h0); bus_in(1'b0, 1'b1, 32'h0); #1;
`ifdef MEM_ALIGN_EXC_EN
    chk("al_lw_req", dbus_req, 0); chk("al_lw_adel", exc_adel, 1); chk("al_lw_wreg", mem_wreg, 0); chk("al_lw_stall", stallreq, 0);
    @(negedge clk); op_in(SH, 5'd4, 1'b1, 32'h0, 32'h1, 32'h1234); #1;
    chk("al_sh_req", dbus_req, 0); chk("al_sh_ades", exc_ades, 1); chk("al_sh_adel", exc_adel, 0);
    @(negedge clk); op_in(NOP, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0); bus_in(1'b0, 1'b0, 32'h0);
`else
    chk("al_lw_req", dbus_req, 1); chk("al_lw_sel", dbus_sel, 4'b1111); chk("al_lw_addr", dbus_addr, 0); chk("al_lw_adel", exc_adel, 0);
    @(negedge clk); op_in(NOP, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0); bus_in(1'b0, 1'b0, 32'h0);
    @(negedge clk); op_in(SH, 5'd4, 1'b1, 32'h0, 32'h1, 32'h1234); bus_in(1'b0, 1'b1, 32'h0); #1;
    chk("al_sh_req", dbus_req, 1); chk("al_sh_sel", dbus_sel, 4'b1100); chk("al_sh_addr", dbus_addr, 0);
    chk("al_sh_wdata", dbus_wdata, 32'h1234_1234); chk("al_sh_ades", exc_ades, 0);
    @(negedge clk); op_in(NOP, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0); bus_in(1'b0, 1'b0, 32'h0);
`endif
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
